// File: rtl/iter_div_pkg.sv
// -----------------------------------------------------------------------------
// iter_div_pkg
// Shared definitions for the iterative restoring divider:
//   - state_e      : controller states (IDLE / RUN / DONE)
//   - clog2()      : ceiling log2, used to size the step counter
//   - DEF_WIDTH_N  : default numerator / quotient width
//   - DEF_WIDTH_D  : default denominator / remainder width
// No ports (package).
// -----------------------------------------------------------------------------
package iter_div_pkg;

   localparam int DEF_WIDTH_N = 8;
   localparam int DEF_WIDTH_D = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Smallest r with 2**r >= value; returns 1 for value <= 2 so that a
   // counter sized from it never collapses to zero bits.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/iter_divide_seq_step.sv
// -----------------------------------------------------------------------------
// iter_div_step
// One restoring-division iteration (pure combinational).
// Ports:
//   prem_i  [width_d:0]   partial remainder from the previous iteration
//   bit_i                 next numerator bit (MSB first)
//   denom_i [width_d-1:0] divisor magnitude
//   prem_o  [width_d:0]   partial remainder after this iteration
//   qbit_o                quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module iter_div_step #(
   parameter int width_d = 8
) (
   input  logic [width_d:0]   prem_i,
   input  logic               bit_i,
   input  logic [width_d-1:0] denom_i,
   output logic [width_d:0]   prem_o,
   output logic               qbit_o
);

   logic [width_d+1:0] shifted;
   logic [width_d:0]   diff;

   // The compare uses the full shifted value so a zero divisor (where the
   // partial remainder is allowed to fill all width_d+1 bits) still yields
   // a quotient bit of 1 on every step.
   assign shifted = {prem_i, bit_i};
   assign diff    = shifted[width_d:0] - {1'b0, denom_i};
   assign qbit_o  = (shifted >= {2'b00, denom_i});
   assign prem_o  = qbit_o ? diff : shifted[width_d:0];

endmodule

// File: rtl/iter_divide_seq.sv
// -----------------------------------------------------------------------------
// iter_divide_seq
// Sequential restoring divider, one quotient bit per enabled clock, with a
// start/done handshake. Results hold until the next completed operation.
// Optional macro ITER_DIV_SIGNED_EN adds two's-complement (truncating)
// division selected per operation by signed_op.
// Ports:
//   clock0       in   sole clock, rising edge
//   sclr         in   synchronous active-high reset (wins over ena0)
//   ena0         in   clock enable; low freezes all state
//   start        in   request, accepted in IDLE with ena0=1
//   numer        in   dividend  [width_n-1:0]
//   denom        in   divisor   [width_d-1:0]
//   signed_op    in   signed request (used only with ITER_DIV_SIGNED_EN)
//   busy         out  accepted start through done cycle inclusive
//   done         out  one-cycle completion pulse
//   quotient     out  [width_n-1:0]
//   remain       out  [width_d-1:0]
//   div_by_zero  out  divisor was zero
// -----------------------------------------------------------------------------
module iter_divide_seq
   import iter_div_pkg::*;
#(
   parameter int width_n = DEF_WIDTH_N,
   parameter int width_d = DEF_WIDTH_D
) (
   input  logic               clock0,
   input  logic               sclr,
   input  logic               ena0,
   input  logic               start,
   input  logic [width_n-1:0] numer,
   input  logic [width_d-1:0] denom,
   input  logic               signed_op,
   output logic               busy,
   output logic               done,
   output logic [width_n-1:0] quotient,
   output logic [width_d-1:0] remain,
   output logic               div_by_zero
);

   localparam int CNT_W = clog2(width_n + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [width_n-1:0] num_q, num_d;
   logic [width_n-1:0] acc_q, acc_d;
   logic [width_d-1:0] den_q, den_d;
   logic [width_d:0]   prem_q, prem_d;
   logic               zden_q, zden_d;
   logic [width_n-1:0] quo_q, quo_d;
   logic [width_d-1:0] rem_q, rem_d;
   logic               dbz_q, dbz_d;

   logic [width_d:0]   prem_nxt;
   logic               qbit;

   // Operand magnitudes on the way in and corrected results on the way out.
   logic [width_n-1:0] num_mag;
   logic [width_d-1:0] den_mag;
   logic [width_n-1:0] q_fin;
   logic [width_d-1:0] r_fin;

`ifdef ITER_DIV_SIGNED_EN
   logic negq_q, negq_d;
   logic negr_q, negr_d;
   logic sgn_num, sgn_den;

   assign sgn_num = signed_op & numer[width_n-1];
   assign sgn_den = signed_op & denom[width_d-1];
   assign num_mag = sgn_num ? (~numer + 1'b1) : numer;
   assign den_mag = sgn_den ? (~denom + 1'b1) : denom;
   // Truncating division: quotient negative when signs differ, remainder
   // follows the dividend. The most negative dividend over -1 wraps.
   assign q_fin   = negq_q ? (~acc_q + 1'b1) : acc_q;
   assign r_fin   = negr_q ? (~prem_q[width_d-1:0] + 1'b1) : prem_q[width_d-1:0];
`else
   logic signed_op_unused;

   assign signed_op_unused = signed_op;
   assign num_mag = numer;
   assign den_mag = denom;
   assign q_fin   = acc_q;
   assign r_fin   = prem_q[width_d-1:0];
`endif

   iter_div_step #(
      .width_d (width_d)
   ) u_step (
      .prem_i  (prem_q),
      .bit_i   (num_q[width_n-1]),
      .denom_i (den_q),
      .prem_o  (prem_nxt),
      .qbit_o  (qbit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      acc_d   = acc_q;
      den_d   = den_q;
      prem_d  = prem_q;
      zden_d  = zden_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
`ifdef ITER_DIV_SIGNED_EN
      negq_d  = negq_q;
      negr_d  = negr_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               num_d   = num_mag;
               den_d   = den_mag;
               acc_d   = '0;
               prem_d  = '0;
               cnt_d   = CNT_W'(width_n);
               zden_d  = (denom == '0);
`ifdef ITER_DIV_SIGNED_EN
               negq_d  = sgn_num ^ sgn_den;
               negr_d  = sgn_num;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_q != '0) begin
               prem_d = prem_nxt;
               acc_d  = {acc_q[width_n-2:0], qbit};
               num_d  = {num_q[width_n-2:0], 1'b0};
               cnt_d  = cnt_q - CNT_W'(1);
            end else begin
               // All bits retired: the closing RUN cycle applies the sign
               // correction and publishes the result for the DONE cycle.
               quo_d   = q_fin;
               rem_d   = r_fin;
               dbz_d   = zden_q;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and published results: cleared by sclr, frozen by ena0.
   always_ff @(posedge clock0) begin
      if (sclr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else if (ena0) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   // Working datapath: always reloaded on an accepted start, so no reset.
   always_ff @(posedge clock0) begin
      if (ena0) begin
         num_q  <= num_d;
         acc_q  <= acc_d;
         den_q  <= den_d;
         prem_q <= prem_d;
         zden_q <= zden_d;
`ifdef ITER_DIV_SIGNED_EN
         negq_q <= negq_d;
         negr_q <= negr_d;
`endif
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign quotient    = quo_q;
   assign remain      = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divide_seq.sv
module tb_iter_divide_seq;

   logic       clock0 = 1'b0;
   logic       sclr = 1'b1;
   logic       ena0 = 1'b1;
   logic       start = 1'b0;
   logic [7:0] numer = '0;
   logic [7:0] denom = '0;
   logic       signed_op = 1'b0;
   logic       busy, done, div_by_zero;
   logic [7:0] quotient, remain;

   int n_vec = 0;
   int n_err = 0;

   iter_divide_seq #(.width_n(8), .width_d(8)) dut (
      .clock0      (clock0),
      .sclr        (sclr),
      .ena0        (ena0),
      .start       (start),
      .numer       (numer),
      .denom       (denom),
      .signed_op   (signed_op),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remain      (remain),
      .div_by_zero (div_by_zero)
   );

   always #5 clock0 = ~clock0;

   task automatic tick();
      @(posedge clock0);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive a start for one edge; returns with the request already accepted.
   task automatic issue(input logic [7:0] n, input logic [7:0] d, input logic s);
      numer = n; denom = d; signed_op = s; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Count edges until done, bounded.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                               input logic z);
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".quot"}, 32'(quotient), 32'(q));
      chk({tag, ".rem"}, 32'(remain), 32'(r));
      chk({tag, ".dbz"}, 32'(div_by_zero), 32'(z));
   endtask

   initial begin
      int  cyc;
      logic saw_done;

      // Reset state
      tick(); tick();
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.quot", 32'(quotient), 32'd0);
      chk("rst.rem", 32'(remain), 32'd0);
      chk("rst.dbz", 32'(div_by_zero), 32'd0);
      sclr = 1'b0;
      tick();

      // 100 / 7 = 14 r 2, latency 9, then held through idle
      issue(8'd100, 8'd7, 1'b0);
      chk("t1.busy", 32'(busy), 32'd1);
      wait_done(cyc);
      chk("t1.lat", 32'(cyc), 32'd9);
      check_result("t1", 8'd14, 8'd2, 1'b0);
      tick();
      chk("t1.done_clr", 32'(done), 32'd0);
      chk("t1.busy_clr", 32'(busy), 32'd0);
      for (int i = 0; i < 20; i++) tick();
      chk("t1.hold_q", 32'(quotient), 32'd14);
      chk("t1.hold_r", 32'(remain), 32'd2);

      // 255 / 1, then divide by zero 37 / 0
      issue(8'd255, 8'd1, 1'b0);
      wait_done(cyc);
      chk("t2.lat", 32'(cyc), 32'd9);
      check_result("t2", 8'd255, 8'd0, 1'b0);
      tick();
      issue(8'd37, 8'd0, 1'b0);
      wait_done(cyc);
      chk("t3.lat", 32'(cyc), 32'd9);
      check_result("t3", 8'd255, 8'd37, 1'b1);
      tick();

      // Starts while busy and in the DONE cycle are ignored
      issue(8'd100, 8'd7, 1'b0);
      tick(); tick(); tick();                 // cycle 3
      issue(8'd50, 8'd5, 1'b0);               // now cycle 4
      for (int i = 0; i < 5; i++) tick();     // cycle 9
      check_result("t4", 8'd14, 8'd2, 1'b0);
      issue(8'd50, 8'd5, 1'b0);               // in DONE, cycle 10
      chk("t4.ign_busy", 32'(busy), 32'd0);
      issue(8'd50, 8'd5, 1'b0);
      wait_done(cyc);
      chk("t5.lat", 32'(cyc), 32'd9);
      check_result("t5", 8'd10, 8'd0, 1'b0);
      tick();

      // Reset mid-operation aborts it
      issue(8'd200, 8'd3, 1'b0);
      tick(); tick(); tick();                 // cycle 3
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      chk("t6.busy", 32'(busy), 32'd0);
      chk("t6.done", 32'(done), 32'd0);
      chk("t6.quot", 32'(quotient), 32'd0);
      chk("t6.rem", 32'(remain), 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done === 1'b1) saw_done = 1'b1;
      end
      chk("t6.no_done", 32'(saw_done), 32'd0);
      issue(8'd9, 8'd4, 1'b0);
      wait_done(cyc);
      chk("t7.lat", 32'(cyc), 32'd9);
      check_result("t7", 8'd2, 8'd1, 1'b0);
      tick();

      // Clock-enable gap of 5 cycles mid-RUN stretches latency to 14
      issue(8'd100, 8'd7, 1'b0);
      tick(); tick(); tick();
      ena0 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      ena0 = 1'b1;
      wait_done(cyc);
      chk("t8.lat", 32'(cyc + 8), 32'd14);
      check_result("t8", 8'd14, 8'd2, 1'b0);
      tick();

      // Signed requests (or unsigned interpretation without the feature)
      issue(8'hF9, 8'd2, 1'b1);
      wait_done(cyc);
      chk("t9.lat", 32'(cyc), 32'd9);
`ifdef ITER_DIV_SIGNED_EN
      check_result("t9", 8'hFD, 8'hFF, 1'b0);
`else
      check_result("t9", 8'd124, 8'd1, 1'b0);
`endif
      tick();
      issue(8'h80, 8'hFF, 1'b1);
      wait_done(cyc);
      chk("t10.lat", 32'(cyc), 32'd9);
`ifdef ITER_DIV_SIGNED_EN
      check_result("t10", 8'h80, 8'h00, 1'b0);
`else
      check_result("t10", 8'd0, 8'd128, 1'b0);
`endif
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time guard in case the stimulus itself stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed time limit, required $finish");
      $fatal(1, "timeout");
   end

endmodule
